// File: rtl/imm_gen_stage.sv
// imm_gen_stage: ID-stage immediate generator feeding a small ID/EX FIFO.
// Optional macro IMM_ZEXT_LOGIC_EN: andi/ori/xori zero-extend (kind ZEXT) instead of sign-extending.
module imm_gen_stage #(
    parameter int BUF_DEPTH = 2,
    parameter int BR_SHIFT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] imm_out,
    output logic [2:0]  imm_kind,
    output logic [31:0] target
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_SEXT = 3'd1;
    localparam logic [2:0] K_LUI  = 3'd3;
    localparam logic [2:0] K_BR   = 3'd4;
    localparam logic [2:0] K_JMP  = 3'd5;
`ifdef IMM_ZEXT_LOGIC_EN
    localparam logic [2:0] K_ZEXT = 3'd2;
`endif

    logic [5:0]    op;
    logic [15:0]   imm;
    logic [31:0]   sext;
    logic [31:0]   dec_imm, dec_tgt;
    logic [2:0]    dec_kind;
    logic          push, pop;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_imm_q [BUF_DEPTH];
    logic [31:0]   mem_imm_d [BUF_DEPTH];
    logic [31:0]   mem_tgt_q [BUF_DEPTH];
    logic [31:0]   mem_tgt_d [BUF_DEPTH];
    logic [2:0]    mem_kind_q [BUF_DEPTH];
    logic [2:0]    mem_kind_d [BUF_DEPTH];

    assign op        = instr[31:26];
    assign imm       = instr[15:0];
    assign sext      = {{16{imm[15]}}, imm};
    assign in_ready  = count_q < FULL;
    assign out_valid = count_q != '0;
    assign imm_out   = mem_imm_q[head_q];
    assign imm_kind  = mem_kind_q[head_q];
    assign target    = mem_tgt_q[head_q];
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Decode the incoming opcode into extension kind, immediate and target
    always_comb begin
        dec_kind = K_SEXT;
        dec_imm  = sext;
        dec_tgt  = '0;
        case (op)
            6'h00: begin
                dec_kind = K_NONE;
                dec_imm  = '0;
            end
`ifdef IMM_ZEXT_LOGIC_EN
            6'h0C, 6'h0D, 6'h0E: begin
                dec_kind = K_ZEXT;
                dec_imm  = {16'h0, imm};
            end
`else
            6'h0C, 6'h0D, 6'h0E: begin
                dec_kind = K_SEXT;
                dec_imm  = sext;
            end
`endif
            6'h0F: begin
                dec_kind = K_LUI;
                dec_imm  = {imm, 16'h0};
            end
            6'h04, 6'h05: begin
                dec_kind = K_BR;
                dec_imm  = sext << BR_SHIFT;
                dec_tgt  = pc_plus4 + dec_imm;
            end
            6'h02, 6'h03: begin
                dec_kind = K_JMP;
                dec_imm  = {pc_plus4[31:28], instr[25:0], 2'b00};
                dec_tgt  = dec_imm;
            end
            default: ;
        endcase
    end

    // FIFO next state: flush wins over push and pop, tail entry written on push
    always_comb begin
        head_d     = flush ? '0 : (pop ? nxt(head_q) : head_q);
        tail_d     = flush ? '0 : (push ? nxt(tail_q) : tail_q);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        mem_imm_d  = mem_imm_q;
        mem_tgt_d  = mem_tgt_q;
        mem_kind_d = mem_kind_q;
        if (push) begin
            mem_imm_d[tail_q]  = dec_imm;
            mem_tgt_d[tail_q]  = dec_tgt;
            mem_kind_d[tail_q] = dec_kind;
        end
    end

    // State registers; asynchronous reset clears pointers and every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_imm_q  <= '{default: '0};
            mem_tgt_q  <= '{default: '0};
            mem_kind_q <= '{default: '0};
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_imm_q  <= mem_imm_d;
            mem_tgt_q  <= mem_tgt_d;
            mem_kind_q <= mem_kind_d;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: randomized check of imm_gen_stage against a queue-based reference model.
module tb_imm_gen_stage;
    localparam int D  = 2;
    localparam int SH = 2;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] instr = 0, pc_plus4 = 0;
    logic        in_ready, out_valid;
    logic [31:0] imm_out, target;
    logic [2:0]  imm_kind;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  kind;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0, n_fail = 0;

    imm_gen_stage #(.BUF_DEPTH(D), .BR_SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_plus4(pc_plus4), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .imm_kind(imm_kind), .target(target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        ent_t e;
        int unsigned op;
        int signed simm;
        op   = int'(ins[31:26]);
        simm = int'($signed(ins[15:0]));
        e.tgt = 0;
        if (op == 0) begin
            e.kind = 0; e.imm = 0;
        end else if (op >= 12 && op <= 14) begin
`ifdef IMM_ZEXT_LOGIC_EN
            e.kind = 2; e.imm = 32'(ins[15:0]);
`else
            e.kind = 1; e.imm = 32'(simm);
`endif
        end else if (op == 15) begin
            e.kind = 3; e.imm = 32'(ins[15:0]) * 32'd65536;
        end else if (op == 4 || op == 5) begin
            e.kind = 4; e.imm = 32'(simm * (2 ** SH)); e.tgt = pc + e.imm;
        end else if (op == 2 || op == 3) begin
            e.kind = 5; e.imm = (pc & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4; e.tgt = e.imm;
        end else begin
            e.kind = 1; e.imm = 32'(simm);
        end
        return e;
    endfunction

    task automatic check_state();
        chk("in_ready", 32'(in_ready), 32'(q.size() < D));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("imm_out", imm_out, q[0].imm);
            chk("imm_kind", 32'(imm_kind), 32'(q[0].kind));
            chk("target", target, q[0].tgt);
        end
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        bit psh, pp;
        @(negedge clk);
        check_state();
        in_valid = iv; instr = ins; pc_plus4 = pc; out_ready = ordy; flush = fl;
        psh = iv && q.size() < D && !fl;
        pp  = q.size() > 0 && ordy && !fl;
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(ref_dec(ins, pc));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_state();
        in_valid = 0; out_ready = 0; flush = 0;
    endtask

    initial begin
        logic [5:0]  ops [12];
        logic [31:0] r;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h3F};
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_imm_out", imm_out, 0);
        chk("rst_kind", 32'(imm_kind), 0);
        chk("rst_target", target, 0);
        rst = 0;

        cyc(1, 32'h2008FFFC, 32'h100, 1, 0); settle();
        chk("addi_imm", imm_out, 32'hFFFFFFFC);
        chk("addi_kind", 32'(imm_kind), 1);
        chk("addi_tgt", target, 0);
        cyc(1, 32'h3408F000, 32'h0, 1, 0); settle();
`ifdef IMM_ZEXT_LOGIC_EN
        chk("ori_imm", imm_out, 32'h0000F000);
        chk("ori_kind", 32'(imm_kind), 2);
`else
        chk("ori_imm", imm_out, 32'hFFFFF000);
        chk("ori_kind", 32'(imm_kind), 1);
`endif
        cyc(1, 32'h3C081234, 32'h0, 1, 0); settle();
        chk("lui_imm", imm_out, 32'h12340000);
        chk("lui_kind", 32'(imm_kind), 3);
        cyc(1, 32'h1109FFFF, 32'h10, 1, 0); settle();
        chk("beq_imm", imm_out, 32'hFFFFFFFC);
        chk("beq_tgt", target, 32'h0000000C);
        chk("beq_kind", 32'(imm_kind), 4);
        cyc(1, 32'h08000040, 32'hF0000004, 1, 0); settle();
        chk("j_tgt", target, 32'hF0000100);
        chk("j_kind", 32'(imm_kind), 5);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 32'h20010001, 32'h4, 0, 0);
        cyc(1, 32'h20020002, 32'h8, 0, 0);
        cyc(1, 32'h20030003, 32'hC, 0, 0); settle();
        chk("full_in_ready", 32'(in_ready), 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        cyc(1, 32'h20040004, 32'h10, 0, 0);
        cyc(1, 32'h20050005, 32'h14, 0, 0);
        cyc(1, 32'h20060006, 32'h18, 1, 1); settle();
        chk("flush2_out_valid", 32'(out_valid), 0);
        cyc(1, 32'h20070007, 32'h1C, 0, 0);
        cyc(1, 32'h20080008, 32'h20, 1, 1); settle();
        chk("flush1_out_valid", 32'(out_valid), 0);
        chk("flush1_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            cyc($urandom_range(0, 3) != 0, {ops[$urandom_range(0, 11)], r[25:0]}, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        settle();

        cyc(1, 32'h2008FFFC, 32'h0, 0, 0); settle();
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_imm_out", imm_out, 0);
        chk("arst_kind", 32'(imm_kind), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        q.delete();
        @(negedge clk);
        rst = 0;
        cyc(0, 0, 0, 0, 0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
